// File: rtl/llr_loader.sv
// llr_loader: input stage of the LLR shift memory.
// Accepts one LLR per cycle over a valid/ready stream, packs LANES consecutive
// LLRs into one word (byte j = j-th LLR of the group) and issues one write
// strobe per word. Tracks the codeword length chosen at start and pulses
// o_done one cycle after the final write.
// Optional feature macro: LLR_LOADER_ZERO_FILL_EN -- after the last data word,
// zero words are written until the memory holds MAX_N/LANES words in total.
module llr_loader #(
    parameter int W_LLR = 8,
    parameter int LANES = 8,
    parameter int MAX_N = 1024
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_start,
    input  logic [1:0]               i_n_sel,
    input  logic                     i_valid,
    input  logic [W_LLR-1:0]         i_llr,
    output logic                     o_ready,
    output logic                     o_wen,
    output logic [W_LLR*LANES-1:0]   o_data,
    output logic                     o_busy,
    output logic                     o_done
);

    localparam int W_DATA    = W_LLR * LANES;
    localparam int MAX_WORDS = MAX_N / LANES;
    localparam int W_BYTE    = $clog2(LANES);

    localparam logic [7:0]        LAST_MEM_WORD = 8'(MAX_WORDS - 1);
    localparam logic [W_BYTE-1:0] LAST_LANE     = W_BYTE'(LANES - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_FILL = 3'd2,
        S_LAST = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t              state_r;
    logic [7:0]          n_words_r;
    logic [W_BYTE-1:0]   byte_cnt_r;
    logic [7:0]          word_cnt_r;
    logic [W_DATA-1:0]   pack_r;

    logic                accept_s;
    logic                group_full_s;
    logic                last_word_s;
    logic [W_DATA-1:0]   word_s;

    // Number of packed words in a codeword for each length selector.
    function automatic logic [7:0] n_words_f(input logic [1:0] sel);
        logic [7:0] words;
        case (sel)
            2'd0:    words = 8'd16;
            2'd1:    words = 8'd32;
            2'd2:    words = 8'd64;
            2'd3:    words = 8'd128;
            default: words = 8'd16;
        endcase
        return words;
    endfunction

    assign accept_s     = i_valid & o_ready;
    assign group_full_s = accept_s && (byte_cnt_r == LAST_LANE);
    assign last_word_s  = (word_cnt_r == (n_words_r - 8'd1));

    // Completed word: lanes gathered so far with the arriving LLR in the top lane.
    always_comb begin
        word_s                     = pack_r;
        word_s[W_DATA-1 -: W_LLR]  = i_llr;
    end

    // Control FSM, lane packing and all registered outputs.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_r    <= S_IDLE;
            n_words_r  <= 8'd0;
            byte_cnt_r <= '0;
            word_cnt_r <= 8'd0;
            pack_r     <= '0;
            o_ready    <= 1'b0;
            o_wen      <= 1'b0;
            o_data     <= '0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
        end else begin
            o_wen  <= 1'b0;
            o_done <= 1'b0;
            case (state_r)
                S_IDLE, S_DONE: begin
                    if (i_start) begin
                        state_r    <= S_LOAD;
                        n_words_r  <= n_words_f(i_n_sel);
                        byte_cnt_r <= '0;
                        word_cnt_r <= 8'd0;
                        o_ready    <= 1'b1;
                        o_busy     <= 1'b1;
                    end else begin
                        state_r <= S_IDLE;
                        o_ready <= 1'b0;
                        o_busy  <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (accept_s) begin
                        pack_r[int'(byte_cnt_r) * W_LLR +: W_LLR] <= i_llr;
                        byte_cnt_r <= byte_cnt_r + 1'b1;
                        if (group_full_s) begin
                            o_wen      <= 1'b1;
                            o_data     <= word_s;
                            word_cnt_r <= word_cnt_r + 8'd1;
                            if (last_word_s) begin
                                o_ready <= 1'b0;
`ifdef LLR_LOADER_ZERO_FILL_EN
                                if (word_cnt_r == LAST_MEM_WORD) begin
                                    state_r <= S_LAST;
                                end else begin
                                    state_r <= S_FILL;
                                end
`else
                                state_r <= S_LAST;
`endif
                            end else begin
                                state_r <= S_LOAD;
                            end
                        end else begin
                            state_r <= S_LOAD;
                        end
                    end else begin
                        state_r <= S_LOAD;
                    end
                end
                S_FILL: begin
                    // Zero words push the codeword up to the top of the memory.
                    o_wen      <= 1'b1;
                    o_data     <= '0;
                    word_cnt_r <= word_cnt_r + 8'd1;
                    if (word_cnt_r == LAST_MEM_WORD) begin
                        state_r <= S_LAST;
                    end else begin
                        state_r <= S_FILL;
                    end
                end
                S_LAST: begin
                    // Final write is on the bus this cycle; completion follows.
                    state_r <= S_DONE;
                    o_ready <= 1'b0;
                    o_busy  <= 1'b0;
                    o_done  <= 1'b1;
                end
                default: begin
                    state_r <= S_IDLE;
                    o_ready <= 1'b0;
                    o_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_llr_loader.sv
// Self-checking bench for llr_loader: a stream-level model predicts every
// output each cycle; literal expectations pin the model on key vectors.
module tb_llr_loader;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b0;
    logic        start   = 1'b0;
    logic [1:0]  n_sel   = 2'd0;
    logic        valid   = 1'b0;
    logic [7:0]  llr     = 8'd0;
    logic        ready, wen, busy, done;
    logic [63:0] data;

`ifdef LLR_LOADER_ZERO_FILL_EN
    localparam bit FILL_EN = 1'b1;
`else
    localparam bit FILL_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    llr_loader dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_start (start),
        .i_n_sel (n_sel),
        .i_valid (valid),
        .i_llr   (llr),
        .o_ready (ready),
        .o_wen   (wen),
        .o_data  (data),
        .o_busy  (busy),
        .o_done  (done)
    );

    // ---------------- model ----------------
    typedef struct { logic wen; logic [63:0] data; logic done; } ev_t;

    bit          m_ok = 1'b0;
    int          m_phase;        // 0 idle/done, 1 loading, 2 trailing writes
    int          m_n, m_acc;
    logic [7:0]  m_grp[$];
    ev_t         m_sched[$];
    logic        m_ready, m_busy, m_done, m_wen;
    logic [63:0] m_data;

    int n_checks = 0, n_fail = 0;
    int cyc = 0, wen_cnt = 0, zero_wen_cnt = 0, last_wen_cyc = 0, done_cyc = 0;
    logic [63:0] first_word;
    bit got_first = 1'b0;

    function void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function void take_sched();
        ev_t ev;
        ev = m_sched.pop_front();
        m_ready = 1'b0;
        if (ev.done) begin
            m_busy  = 1'b0;
            m_done  = 1'b1;
            m_phase = 0;
        end else begin
            m_busy = 1'b1;
            m_wen  = ev.wen;
            if (ev.wen) m_data = ev.data;
        end
    endfunction

    // Advance the model across one rising edge using the inputs held at that edge.
    function void model_step();
        logic [63:0] w;
        if (!rst_n) begin
            m_ok = 1'b1; m_phase = 0;
            m_ready = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_wen = 1'b0;
            m_data = 64'd0;
            m_grp.delete(); m_sched.delete();
            return;
        end
        if (!m_ok) return;
        m_wen  = 1'b0;
        m_done = 1'b0;
        case (m_phase)
            0: begin
                if (start) begin
                    m_n = 128 << n_sel; m_acc = 0; m_grp.delete();
                    m_phase = 1; m_ready = 1'b1; m_busy = 1'b1;
                end else begin
                    m_ready = 1'b0; m_busy = 1'b0;
                end
            end
            1: begin
                if (valid) begin
                    m_grp.push_back(llr);
                    m_acc++;
                    if (m_grp.size() == 8) begin
                        for (int j = 0; j < 8; j++) w[8*j +: 8] = m_grp[j];
                        m_grp.delete();
                        if (m_acc == m_n) begin
                            m_sched.push_back('{1'b1, w, 1'b0});
                            if (FILL_EN)
                                for (int k = 0; k < (1024 - m_n) / 8; k++)
                                    m_sched.push_back('{1'b1, 64'd0, 1'b0});
                            m_sched.push_back('{1'b0, 64'd0, 1'b1});
                            m_phase = 2;
                            take_sched();
                        end else begin
                            m_wen = 1'b1; m_data = w;
                        end
                    end
                end
            end
            default: take_sched();
        endcase
    endfunction

    // Compare process: update the model, then check every output each cycle.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            model_step();
            if (m_ok) begin
                chk("ready", 64'(ready), 64'(m_ready));
                chk("busy",  64'(busy),  64'(m_busy));
                chk("done",  64'(done),  64'(m_done));
                chk("wen",   64'(wen),   64'(m_wen));
                chk("data",  data,       m_data);
                if (wen === 1'b1) begin
                    wen_cnt++;
                    last_wen_cyc = cyc;
                    if (data == 64'd0) zero_wen_cnt++;
                    if (!got_first) begin first_word = data; got_first = 1'b1; end
                end
                if (done === 1'b1) done_cyc = cyc;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_start(input logic [1:0] sel);
        start = 1'b1; n_sel = sel;
        step();
        start = 1'b0; n_sel = ~sel;
    endtask

    task automatic send(input int n, input bit gaps, input int base, input int mul, input bit junk);
        int  k = 0;
        int  guard = 0;
        bit  rdy;
        while (k < n && guard < 20000) begin
            valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            llr   = 8'(base + k * mul);
            start = junk ? ($urandom_range(0, 4) == 0) : 1'b0;
            if (junk) n_sel = 2'($urandom_range(0, 3));
            rdy = m_ready;
            step();
            if (valid && rdy) k++;
            guard++;
        end
        valid = 1'b0; start = 1'b0;
        if (k < n) chk("send_timeout", 64'(k), 64'(n));
    endtask

    task automatic wait_done();
        int g = 0;
        while (!m_done && g < 400) begin step(); g++; end
        if (!m_done) chk("wait_done_timeout", 64'(g), 64'd0);
    endtask

    initial begin
        step(); step(); step();
        chk("rst_busy",  64'(busy),  64'd0);
        chk("rst_ready", 64'(ready), 64'd0);
        chk("rst_wen",   64'(wen),   64'd0);
        chk("rst_data",  data,       64'd0);
        rst_n = 1'b1;
        step();

        // 1: N=128, ramp 0..127, valid every cycle.
        wen_cnt = 0; got_first = 1'b0;
        do_start(2'd0);
        chk("t1_busy_after_start", 64'(busy), 64'd1);
        send(128, 1'b0, 0, 1, 1'b0);
        wait_done();
        chk("t1_wen_count", 64'(wen_cnt), FILL_EN ? 64'd128 : 64'd16);
        chk("t1_first_word", first_word, 64'h0706050403020100);
        chk("t1_done_latency", 64'(done_cyc - last_wen_cyc), 64'd1);
        step(); step();

        // 2: N=256 with random valid gaps and stray starts, signed values.
        wen_cnt = 0; zero_wen_cnt = 0;
        do_start(2'd1);
        send(256, 1'b1, 200, 37, 1'b1);
        wait_done();
        chk("t2_wen_count", 64'(wen_cnt), FILL_EN ? 64'd128 : 64'd32);
        step();

        // 3: N=512, zero fill depends on the build.
        wen_cnt = 0; zero_wen_cnt = 0;
        do_start(2'd2);
        send(512, 1'b0, 3, 1, 1'b0);
        wait_done();
        chk("t3_wen_count", 64'(wen_cnt), FILL_EN ? 64'd128 : 64'd64);
        chk("t3_zero_words", 64'(zero_wen_cnt), FILL_EN ? 64'd64 : 64'd0);
        chk("t3_done_latency", 64'(done_cyc - last_wen_cyc), 64'd1);
        step();

        // 4: reset after 5 LLRs of the 3rd word, then clean reload.
        wen_cnt = 0;
        do_start(2'd0);
        send(21, 1'b0, 50, 1, 1'b0);
        chk("t4_words_before_rst", 64'(wen_cnt), 64'd2);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        wen_cnt = 0;
        for (int i = 0; i < 5; i++) step();
        chk("t4_no_wen_after_rst", 64'(wen_cnt), 64'd0);
        chk("t4_busy_after_rst", 64'(busy), 64'd0);
        got_first = 1'b0;
        do_start(2'd0);
        send(128, 1'b0, 100, 1, 1'b0);
        wait_done();
        chk("t4_first_word", first_word, 64'h6B6A696867666564);
        chk("t4_wen_count", 64'(wen_cnt), FILL_EN ? 64'd128 : 64'd16);

        // 5: start accepted in the done cycle; stray starts while busy ignored.
        step();
        do_start(2'd0);
        send(128, 1'b1, 9, 3, 1'b1);
        wait_done();
        wen_cnt = 0;
        do_start(2'd3);
        chk("t5_busy_reassert", 64'(busy), 64'd1);
        send(1024, 1'b0, 5, 1, 1'b1);
        wait_done();
        chk("t5_wen_count", 64'(wen_cnt), 64'd128);
        step(); step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
